cache_controller: RTL and testbench

Sequencing FSM for the direct-mapped, one-word-per-line instruction/data cache array in the RISC-V pipeline. It sits between the CPU memory stage, the cache storage arrays (tag/valid/data) and main memory. It performs hit/miss detection, sequences miss refills over a request/acknowledge memory handshake, and runs invalidation sweeps on reset and on flush. It stalls the pipeline while any of these is in progress.

---
 rtl/cache_controller.sv | 174 +++++++++++++++++
 tb/tb_cache_controller.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped, one-word-per-line cache: hit/miss lookup,
// miss refill over a req/ack memory handshake, and invalidation sweeps on reset and flush.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// SWEEP  | writing V=0 to every line, one index per cycle; pipeline stalled
// IDLE   | looking up CPU requests; hits return data in the same cycle
// REFILL | waiting for main memory; the ack cycle writes the line and returns data
module cache_controller #(
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 26,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iReq,
    input  logic [31:0]            iAddress,
    input  logic                   iFlush,
    output logic                   oStall,
    output logic                   oRdValid,
    output logic [DATA_WIDTH-1:0]  oRdData,
    output logic [INDEX_WIDTH-1:0] oIndex,
    input  logic [TAG_WIDTH-1:0]   iTag,
    input  logic                   iV,
    input  logic [DATA_WIDTH-1:0]  iCacheData,
    output logic                   oWrEn,
    output logic [TAG_WIDTH-1:0]   oWrTag,
    output logic                   oWrV,
    output logic [DATA_WIDTH-1:0]  oWrData,
    output logic                   oMemReq,
    output logic [31:0]            oMemAddress,
    input  logic                   iMemAck,
    input  logic [DATA_WIDTH-1:0]  iMemData,
    output logic [15:0]            oHitCount,
    output logic [15:0]            oMissCount
);

    typedef enum logic [1:0] {
        SWEEP  = 2'd0,
        IDLE   = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
    localparam logic [15:0]            CNT_MAX    = 16'hFFFF;

    state_t                 state, state_next, state_eff;
    logic [INDEX_WIDTH-1:0] sweep_cnt, sweep_cnt_next, sweep_cnt_eff;
    logic                   flush_pend, flush_pend_next;
    logic [31:0]            lat_addr, lat_addr_next;
    logic [15:0]            hit_cnt, miss_cnt;
    logic                   hit_evt, miss_evt;

    logic [INDEX_WIDTH-1:0] req_index, lat_index;
    logic [TAG_WIDTH-1:0]   req_tag, lat_tag;
    logic                   lookup_hit;

    assign req_index  = iAddress[INDEX_WIDTH+1:2];
    assign req_tag    = iAddress[31:INDEX_WIDTH+2];
    assign lat_index  = lat_addr[INDEX_WIDTH+1:2];
    assign lat_tag    = lat_addr[31:INDEX_WIDTH+2];
    assign lookup_hit = iV && (iTag == req_tag);

    // While reset is held the outputs already look like sweep index 0, so an
    // in-flight refill can neither raise oMemReq nor write a valid line.
    assign state_eff     = iRST ? SWEEP : state;
    assign sweep_cnt_eff = iRST ? '0 : sweep_cnt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= SWEEP;
            sweep_cnt  <= '0;
            flush_pend <= 1'b0;
            lat_addr   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state      <= state_next;
            sweep_cnt  <= sweep_cnt_next;
            flush_pend <= flush_pend_next;
            lat_addr   <= lat_addr_next;
            if (hit_evt && (hit_cnt != CNT_MAX)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (miss_evt && (miss_cnt != CNT_MAX)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_next      = state_eff;
        sweep_cnt_next  = sweep_cnt_eff;
        flush_pend_next = flush_pend;
        lat_addr_next   = lat_addr;
        hit_evt         = 1'b0;
        miss_evt        = 1'b0;
        oStall          = 1'b0;
        oRdValid        = 1'b0;
        oRdData         = '0;
        oIndex          = req_index;
        oWrEn           = 1'b0;
        oWrTag          = '0;
        oWrV            = 1'b0;
        oWrData         = '0;
        oMemReq         = 1'b0;
        oMemAddress     = '0;

        case (state_eff)
            SWEEP: begin
                oIndex         = sweep_cnt_eff;
                oWrEn          = 1'b1;
                oStall         = 1'b1;
                sweep_cnt_next = sweep_cnt_eff + 1'b1;
                if (iFlush) begin
                    flush_pend_next = 1'b1;
                end
                if (sweep_cnt_eff == LAST_INDEX) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                // A flush, new or deferred, wins over a request in the same cycle.
                if (iFlush || flush_pend) begin
                    oStall          = 1'b1;
                    state_next      = SWEEP;
                    sweep_cnt_next  = '0;
                    flush_pend_next = 1'b0;
                end else if (iReq) begin
                    if (lookup_hit) begin
                        oRdValid = 1'b1;
                        oRdData  = iCacheData;
                        hit_evt  = 1'b1;
                    end else begin
                        oStall        = 1'b1;
                        miss_evt      = 1'b1;
                        lat_addr_next = iAddress;
                        state_next    = REFILL;
                    end
                end
            end

            REFILL: begin
                oIndex      = lat_index;
                oStall      = 1'b1;
                oMemReq     = 1'b1;
                oMemAddress = {lat_addr[31:2], 2'b00};
                if (iFlush) begin
                    flush_pend_next = 1'b1;
                end
                if (iMemAck) begin
                    oWrEn      = 1'b1;
                    oWrV       = 1'b1;
                    oWrTag     = lat_tag;
                    oWrData    = iMemData;
                    oRdValid   = 1'b1;
                    oRdData    = iMemData;
                    oStall     = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next     = SWEEP;
                sweep_cnt_next = '0;
            end
        endcase
    end

    assign oHitCount  = hit_cnt;
    assign oMissCount = miss_cnt;

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: bench-side storage arrays and memory,
// a line-address reference model, and a monitor that checks every oRdValid.
module tb_cache_controller;

    logic        iCLK;
    logic        iRST;
    logic        iReq;
    logic [31:0] iAddress;
    logic        iFlush;
    logic        oStall;
    logic        oRdValid;
    logic [31:0] oRdData;
    logic [3:0]  oIndex;
    logic [25:0] iTag;
    logic        iV;
    logic [31:0] iCacheData;
    logic        oWrEn;
    logic [25:0] oWrTag;
    logic        oWrV;
    logic [31:0] oWrData;
    logic        oMemReq;
    logic [31:0] oMemAddress;
    logic        iMemAck;
    logic [31:0] iMemData;
    logic [15:0] oHitCount;
    logic [15:0] oMissCount;

    cache_controller dut (
        .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iAddress(iAddress), .iFlush(iFlush),
        .oStall(oStall), .oRdValid(oRdValid), .oRdData(oRdData), .oIndex(oIndex),
        .iTag(iTag), .iV(iV), .iCacheData(iCacheData), .oWrEn(oWrEn), .oWrTag(oWrTag),
        .oWrV(oWrV), .oWrData(oWrData), .oMemReq(oMemReq), .oMemAddress(oMemAddress),
        .iMemAck(iMemAck), .iMemData(iMemData), .oHitCount(oHitCount), .oMissCount(oMissCount)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // Cache storage arrays (asynchronous read, write on rising edge).
    logic        preload;
    logic [25:0] arr_tag  [16];
    logic        arr_v    [16];
    logic [31:0] arr_data [16];

    always @(posedge iCLK) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                arr_v[i]    <= 1'b1;
                arr_tag[i]  <= 26'd1;
                arr_data[i] <= 32'hBAD0_0000 | 32'(i);
            end
        end else if (oWrEn) begin
            arr_v[oIndex]    <= oWrV;
            arr_tag[oIndex]  <= oWrTag;
            arr_data[oIndex] <= oWrData;
        end
    end

    assign iTag       = arr_tag[oIndex];
    assign iV         = arr_v[oIndex];
    assign iCacheData = arr_data[oIndex];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
    } exp_t;

    exp_t        exp_q[$];
    logic [29:0] ref_line [int];
    int          model_hits;
    int          model_misses;
    int          n_cmp;
    int          n_bad;
    int          mem_lat;
    logic [31:0] exp_mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0044) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[5:2]);
        return ref_line.exists(idx) && (ref_line[idx] == a[31:2]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        bit   stalled;
        stalled = 1'b0;
        forever begin
            @(negedge iCLK);
            if (iReq && oStall) stalled = 1'b1;
            if (oRdValid) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", 32'(oRdValid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", oRdData, e.data);
                    chk("rd_addr", iAddress, e.addr);
                    chk("rd_hit", 32'(!stalled), 32'(e.hit));
                end
                stalled = 1'b0;
            end else if (!iReq) begin
                stalled = 1'b0;
            end
        end
    endtask

    // Memory: acks mem_lat cycles after oMemReq rises and checks the refill write.
    task automatic mem_loop();
        logic [31:0] ea;
        int          n;
        bit          rst_seen;
        forever begin
            @(negedge iCLK);
            if (oMemReq && !iRST) begin
                ea       = exp_mem_addr;
                n        = mem_lat;
                rst_seen = 1'b0;
                chk("mem_addr", oMemAddress, ea);
                for (int j = 1; j <= n; j++) begin
                    @(posedge iCLK); #1;
                    if (j == n) begin
                        iMemAck  = 1'b1;
                        iMemData = mem_word(ea);
                    end
                    @(negedge iCLK);
                    if (iRST) rst_seen = 1'b1;
                    if (!rst_seen) begin
                        chk("mem_req_held", 32'(oMemReq), 32'd1);
                        chk("mem_addr_held", oMemAddress, ea);
                        if (j == n) begin
                            chk("fill_wren", 32'(oWrEn), 32'd1);
                            chk("fill_wrv", 32'(oWrV), 32'd1);
                            chk("fill_tag", 32'(oWrTag), 32'(ea[31:6]));
                            chk("fill_index", 32'(oIndex), 32'(ea[5:2]));
                            chk("fill_data", oWrData, mem_word(ea));
                        end
                    end
                end
                @(posedge iCLK); #1;
                iMemAck = 1'b0;
            end
        end
    endtask

    // fmode: 0 plain, 1 iFlush together with the request, 2 iFlush in the first refill cycle.
    task automatic do_read(input logic [31:0] a, input int fmode, input int lat);
        exp_t e;
        bit   h;
        bit   done;
        if (fmode == 1) ref_line.delete();
        h = model_hit(a);
        if (h) begin
            model_hits++;
        end else begin
            model_misses++;
            ref_line[int'(a[5:2])] = a[31:2];
        end
        exp_mem_addr = {a[31:2], 2'b00};
        mem_lat      = lat;
        e.addr = a;
        e.data = mem_word({a[31:2], 2'b00});
        e.hit  = h;
        exp_q.push_back(e);
        iReq     = 1'b1;
        iAddress = a;
        iFlush   = (fmode == 1);
        done     = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge iCLK);
            if (!oStall) done = 1'b1;
            @(posedge iCLK); #1;
            iFlush = (fmode == 2) && (k == 0) && !done;
        end
        iReq   = 1'b0;
        iFlush = 1'b0;
        if (!done) chk("read_timeout", 32'(done), 32'd1);
        if (fmode == 2) ref_line.delete();
    endtask

    task automatic chk_counts(input string tag);
        @(negedge iCLK);
        chk({tag, "_hits"}, 32'(oHitCount), 32'(model_hits));
        chk({tag, "_misses"}, 32'(oMissCount), 32'(model_misses));
        @(posedge iCLK); #1;
    endtask

    initial begin
        logic [31:0] a;
        int          fm, prev_fm, lat, ack_seen;

        n_cmp = 0; n_bad = 0; model_hits = 0; model_misses = 0;
        mem_lat = 1; exp_mem_addr = '0;
        iRST = 1'b1; preload = 1'b1; iReq = 1'b0; iAddress = '0; iFlush = 1'b0;
        iMemAck = 1'b0; iMemData = '0;

        fork
            monitor_loop();
            mem_loop();
            begin
                #500_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset and power-on sweep over a preloaded, all-valid array.
        @(posedge iCLK); #1;
        preload = 1'b0;
        @(negedge iCLK);
        chk("rst_stall", 32'(oStall), 32'd1);
        chk("rst_rdvalid", 32'(oRdValid), 32'd0);
        chk("rst_rddata", oRdData, 32'd0);
        chk("rst_memreq", 32'(oMemReq), 32'd0);
        chk("rst_memaddr", oMemAddress, 32'd0);
        chk("rst_wren", 32'(oWrEn), 32'd1);
        chk("rst_wrv", 32'(oWrV), 32'd0);
        chk("rst_index", 32'(oIndex), 32'd0);
        chk("rst_hits", 32'(oHitCount), 32'd0);
        chk("rst_misses", 32'(oMissCount), 32'd0);
        @(posedge iCLK); #1;
        iRST = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge iCLK);
            chk("sweep_index", 32'(oIndex), 32'(i));
            chk("sweep_wren", 32'(oWrEn), 32'd1);
            chk("sweep_wrv", 32'(oWrV), 32'd0);
            chk("sweep_stall", 32'(oStall), 32'd1);
        end
        @(negedge iCLK);
        chk("cycle17_stall", 32'(oStall), 32'd0);
        chk("cycle17_wren", 32'(oWrEn), 32'd0);
        @(posedge iCLK); #1;

        // Miss then zero-wait hit.
        do_read(32'h0000_0044, 0, 3);
        do_read(32'h0000_0044, 0, 1);
        chk_counts("miss_hit");

        // Conflict on index 1.
        do_read(32'h0000_0084, 0, 2);
        do_read(32'h0000_0044, 0, 4);
        chk_counts("conflict");

        // Flush while waiting for the ack, then the swept line misses.
        do_read(32'h0000_0088, 2, 3);
        do_read(32'h0000_0044, 0, 2);
        chk_counts("flush_refill");

        // Flush together with a request that would otherwise hit.
        do_read(32'h0000_0044, 0, 1);
        do_read(32'h0000_0044, 1, 2);
        chk_counts("flush_req");

        // Back-to-back hits.
        do_read(32'h0000_0044, 0, 1);
        do_read(32'h0000_0044, 0, 1);
        do_read(32'h0000_0047, 0, 1);
        chk_counts("b2b");

        // Reset in REFILL: the late ack must not fill a line.
        mem_lat      = 6;
        exp_mem_addr = 32'h0000_0148;
        iReq         = 1'b1;
        iAddress     = 32'h0000_0148;
        @(negedge iCLK);
        chk("rstref_lookup_stall", 32'(oStall), 32'd1);
        @(posedge iCLK); #1;
        @(negedge iCLK);
        chk("rstref_memreq_up", 32'(oMemReq), 32'd1);
        @(posedge iCLK); #1;
        iRST = 1'b1;
        iReq = 1'b0;
        @(negedge iCLK);
        chk("rstref_memreq_in_rst", 32'(oMemReq), 32'd0);
        chk("rstref_wrv_in_rst", 32'(oWrV), 32'd0);
        @(posedge iCLK); #1;
        @(negedge iCLK);
        chk("rstref_memreq_next", 32'(oMemReq), 32'd0);
        chk("rstref_hits", 32'(oHitCount), 32'd0);
        chk("rstref_misses", 32'(oMissCount), 32'd0);
        @(posedge iCLK); #1;
        iRST = 1'b0;
        ref_line.delete();
        model_hits   = 0;
        model_misses = 0;
        ack_seen     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            if (iMemAck) ack_seen++;
            chk("rstref_no_fill", 32'(oWrEn && oWrV), 32'd0);
        end
        chk("rstref_late_ack", 32'(ack_seen), 32'd1);
        @(posedge iCLK); #1;
        chk_counts("after_rst");

        // Randomized traffic over a small address pool to mix hits, misses and conflicts.
        prev_fm = 0;
        for (int r = 0; r < 150; r++) begin
            a   = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            lat = int'($urandom_range(1, 4));
            fm  = 0;
            if ($urandom_range(0, 19) == 0) begin
                fm = 1;
            end else if (prev_fm != 2 && !model_hit(a) && $urandom_range(0, 9) == 0) begin
                fm = 2;
            end
            do_read(a, fm, lat);
            prev_fm = fm;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge iCLK);
                #1;
            end
        end
        chk_counts("random");
        chk("exp_q_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
